// File: rtl/rom_arbiter.sv
// Shares one synchronous instruction ROM between the IFU and the LSU read path.
// Optional anti-starvation guard for the LSU is enabled with ROM_ARB_STARVE_GUARD_EN.
module rom_arbiter #(
  parameter int          ADDR_W     = 16,
  parameter int          STARVE_MAX = 4,
  parameter logic [63:0] PC_RST     = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ifu_req_valid,
  output logic              o_ifu_req_ready,
  input  logic [63:0]       i_ifu_req_addr,
  output logic              o_ifu_rsp_valid,
  input  logic              i_ifu_rsp_ready,
  output logic [31:0]       o_ifu_rsp_inst,
  output logic              o_ifu_rsp_err,
  input  logic              i_lsu_req_valid,
  output logic              o_lsu_req_ready,
  input  logic [63:0]       i_lsu_req_addr,
  input  logic              i_lsu_req_dword,
  output logic              o_lsu_rsp_valid,
  input  logic              i_lsu_rsp_ready,
  output logic [63:0]       o_lsu_rsp_data,
  output logic              o_lsu_rsp_err,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_idx,
  input  logic [31:0]       i_rom_rdata,
  output logic [1:0]        o_dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1.
  // req_ready may depend combinationally on either port's req_valid; rsp_valid never
  // depends on rsp_ready, and rsp payload is held while rsp_valid & !rsp_ready.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IFU_RD  = 2'd1,
    ST_LSU_RD0 = 2'd2,
    ST_LSU_RD1 = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [64:0]       w_ifu_diff;
  logic [64:0]       w_lsu_diff;
  logic [ADDR_W-1:0] w_ifu_idx;
  logic [ADDR_W-1:0] w_lsu_idx;
  logic              w_ifu_fault;
  logic              w_lsu_fault;
  logic              w_ifu_elig;
  logic              w_lsu_elig;
  logic              w_lsu_prio;
  logic              w_ifu_grant;
  logic              w_lsu_grant;

  logic [ADDR_W-1:0] r_lsu_idx;
  logic              r_lsu_dword;
  logic [31:0]       r_lsu_lo;

  logic              r_ifu_rsp_valid;
  logic [31:0]       r_ifu_rsp_inst;
  logic              r_ifu_rsp_err;
  logic              r_lsu_rsp_valid;
  logic [63:0]       r_lsu_rsp_data;
  logic              r_lsu_rsp_err;

  // Bit 64 of diff is the borrow (addr below PC_RST). PC_RST is 8-byte aligned, so the
  // low offset bits equal the low address bits.
  function automatic logic addr_fault(input logic [64:0] diff, input logic dword);
    logic below;
    logic above;
    logic misalign;
    logic second_oob;
    below      = diff[64];
    above      = |diff[63:ADDR_W+2];
    misalign   = (diff[1:0] != 2'b00) | (dword & diff[2]);
    second_oob = dword & (&diff[ADDR_W+1:2]);
    return below | above | misalign | second_oob;
  endfunction

  assign w_ifu_diff  = {1'b0, i_ifu_req_addr} - {1'b0, PC_RST};
  assign w_lsu_diff  = {1'b0, i_lsu_req_addr} - {1'b0, PC_RST};
  assign w_ifu_idx   = w_ifu_diff[ADDR_W+1:2];
  assign w_lsu_idx   = w_lsu_diff[ADDR_W+1:2];
  assign w_ifu_fault = addr_fault(w_ifu_diff, 1'b0);
  assign w_lsu_fault = addr_fault(w_lsu_diff, i_lsu_req_dword);

  assign w_ifu_elig = i_ifu_req_valid & (r_state != ST_IFU_RD)
                    & (!r_ifu_rsp_valid | i_ifu_rsp_ready);
  assign w_lsu_elig = i_lsu_req_valid & (r_state != ST_LSU_RD0) & (r_state != ST_LSU_RD1)
                    & (!r_lsu_rsp_valid | i_lsu_rsp_ready);

  assign w_lsu_grant = rst_n & (r_state == ST_IDLE) & w_lsu_elig & (!w_ifu_elig | w_lsu_prio);
  assign w_ifu_grant = rst_n & (r_state == ST_IDLE) & w_ifu_elig & !w_lsu_grant;

  assign o_ifu_req_ready = w_ifu_grant;
  assign o_lsu_req_ready = w_lsu_grant;

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_lsu_prio = (r_starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_lsu_grant) begin
      r_starve_cnt <= '0;
    end else if (w_ifu_grant & w_lsu_elig & !w_lsu_prio) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end
`else
  assign w_lsu_prio = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The second dword beat is issued while the first beat's data returns.
  always_comb begin
    w_state_nxt = r_state;
    o_rom_en    = 1'b0;
    o_rom_idx   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_ifu_grant) begin
          o_rom_idx = w_ifu_idx;
          if (!w_ifu_fault) begin
            o_rom_en    = 1'b1;
            w_state_nxt = ST_IFU_RD;
          end
        end else if (w_lsu_grant) begin
          o_rom_idx = w_lsu_idx;
          if (!w_lsu_fault) begin
            o_rom_en    = 1'b1;
            w_state_nxt = ST_LSU_RD0;
          end
        end
      end
      ST_IFU_RD: w_state_nxt = ST_IDLE;
      ST_LSU_RD0: begin
        if (r_lsu_dword) begin
          o_rom_en    = 1'b1;
          o_rom_idx   = r_lsu_idx + ADDR_W'(1);
          w_state_nxt = ST_LSU_RD1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LSU_RD1: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsu_idx   <= '0;
      r_lsu_dword <= 1'b0;
      r_lsu_lo    <= '0;
    end else begin
      if (w_lsu_grant & !w_lsu_fault) begin
        r_lsu_idx   <= w_lsu_idx;
        r_lsu_dword <= i_lsu_req_dword;
      end
      if (r_state == ST_LSU_RD0) begin
        r_lsu_lo <= i_rom_rdata;
      end
    end
  end

  // Loads take priority over a pop, so a same-cycle pop and load keeps rsp_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifu_rsp_valid <= 1'b0;
      r_ifu_rsp_inst  <= '0;
      r_ifu_rsp_err   <= 1'b0;
    end else if (r_state == ST_IFU_RD) begin
      r_ifu_rsp_valid <= 1'b1;
      r_ifu_rsp_inst  <= i_rom_rdata;
      r_ifu_rsp_err   <= 1'b0;
    end else if (w_ifu_grant & w_ifu_fault) begin
      r_ifu_rsp_valid <= 1'b1;
      r_ifu_rsp_inst  <= '0;
      r_ifu_rsp_err   <= 1'b1;
    end else if (i_ifu_rsp_ready) begin
      r_ifu_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsu_rsp_valid <= 1'b0;
      r_lsu_rsp_data  <= '0;
      r_lsu_rsp_err   <= 1'b0;
    end else if ((r_state == ST_LSU_RD0) & !r_lsu_dword) begin
      r_lsu_rsp_valid <= 1'b1;
      r_lsu_rsp_data  <= {32'h0, i_rom_rdata};
      r_lsu_rsp_err   <= 1'b0;
    end else if (r_state == ST_LSU_RD1) begin
      r_lsu_rsp_valid <= 1'b1;
      r_lsu_rsp_data  <= {i_rom_rdata, r_lsu_lo};
      r_lsu_rsp_err   <= 1'b0;
    end else if (w_lsu_grant & w_lsu_fault) begin
      r_lsu_rsp_valid <= 1'b1;
      r_lsu_rsp_data  <= '0;
      r_lsu_rsp_err   <= 1'b1;
    end else if (i_lsu_rsp_ready) begin
      r_lsu_rsp_valid <= 1'b0;
    end
  end

  assign o_ifu_rsp_valid = r_ifu_rsp_valid;
  assign o_ifu_rsp_inst  = r_ifu_rsp_inst;
  assign o_ifu_rsp_err   = r_ifu_rsp_err;
  assign o_lsu_rsp_valid = r_lsu_rsp_valid;
  assign o_lsu_rsp_data  = r_lsu_rsp_data;
  assign o_lsu_rsp_err   = r_lsu_rsp_err;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table of single reads plus hand-written
// multi-cycle sequences (backpressure, starvation, reset mid-read).
module tb_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_inst;
  logic        ifu_rsp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_dword;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready;
  logic [63:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        rom_en;
  logic [15:0] rom_idx;
  logic [31:0] rom_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  rom_arbiter #(.ADDR_W(16), .STARVE_MAX(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_ifu_req_valid (ifu_req_valid),
    .o_ifu_req_ready (ifu_req_ready),
    .i_ifu_req_addr  (ifu_req_addr),
    .o_ifu_rsp_valid (ifu_rsp_valid),
    .i_ifu_rsp_ready (ifu_rsp_ready),
    .o_ifu_rsp_inst  (ifu_rsp_inst),
    .o_ifu_rsp_err   (ifu_rsp_err),
    .i_lsu_req_valid (lsu_req_valid),
    .o_lsu_req_ready (lsu_req_ready),
    .i_lsu_req_addr  (lsu_req_addr),
    .i_lsu_req_dword (lsu_req_dword),
    .o_lsu_rsp_valid (lsu_rsp_valid),
    .i_lsu_rsp_ready (lsu_rsp_ready),
    .o_lsu_rsp_data  (lsu_rsp_data),
    .o_lsu_rsp_err   (lsu_rsp_err),
    .o_rom_en        (rom_en),
    .o_rom_idx       (rom_idx),
    .i_rom_rdata     (rom_rdata),
    .o_dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a few fixed words, everything else a pattern of the index.
  function automatic logic [31:0] rom_word(input logic [15:0] idx);
    case (idx)
      16'd0:   return 32'h0000_0413;
      16'd2:   return 32'h1111_1111;
      16'd3:   return 32'h2222_2222;
      default: return {idx ^ 16'h5A5A, idx};
    endcase
  endfunction

  always @(posedge clk) rom_rdata <= rom_en ? rom_word(rom_idx) : 32'hDEAD_BEEF;

  typedef struct {
    logic        is_lsu;
    logic [63:0] addr;
    logic        dword;
    logic        exp_err;
    logic [15:0] exp_idx;
    logic [63:0] exp_data;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    logic [63:0] data;
    logic        vld;
    logic        err;
    v = vecs[k];
    tick();
    if (v.is_lsu) begin
      lsu_req_valid = 1'b1; lsu_req_addr = v.addr; lsu_req_dword = v.dword;
    end else begin
      ifu_req_valid = 1'b1; ifu_req_addr = v.addr;
    end
    @(negedge clk);
    check($sformatf("v%0d req_ready", k), v.is_lsu ? lsu_req_ready : ifu_req_ready, 1);
    check($sformatf("v%0d rom_en", k), rom_en, !v.exp_err);
    if (!v.exp_err) check($sformatf("v%0d rom_idx", k), rom_idx, v.exp_idx);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) tick();
      @(negedge clk);
      if (c == 1 && v.dword && !v.exp_err) begin
        check($sformatf("v%0d beat1 rom_en", k), rom_en, 1);
        check($sformatf("v%0d beat1 rom_idx", k), rom_idx, v.exp_idx + 16'd1);
      end
      vld = v.is_lsu ? lsu_rsp_valid : ifu_rsp_valid;
      check($sformatf("v%0d rsp_valid c%0d", k, c), vld, (c == v.lat));
    end
    data = v.is_lsu ? lsu_rsp_data : {32'h0, ifu_rsp_inst};
    err  = v.is_lsu ? lsu_rsp_err : ifu_rsp_err;
    check($sformatf("v%0d rsp_data", k), data, v.exp_data);
    check($sformatf("v%0d rsp_err", k), err, v.exp_err);
    tick();
    @(negedge clk);
    check($sformatf("v%0d rsp popped", k), v.is_lsu ? lsu_rsp_valid : ifu_rsp_valid, 0);
  endtask

  task automatic check_ifu_held(input string name, input logic [31:0] inst);
    check({name, " ifu_rsp_valid"}, ifu_rsp_valid, 1);
    check({name, " ifu_rsp_inst"}, ifu_rsp_inst, inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_ifu;
    logic exp_lsu;

    //             is_lsu addr                      dword err idx       data                    lat
    vecs[0]  = '{1'b0, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 16'h0000, 64'h0000_0000_0000_0413, 2};
    vecs[1]  = '{1'b0, 64'h0000_0000_8000_0010, 1'b0, 1'b0, 16'h0004, 64'h0000_0000_5A5E_0004, 2};
    vecs[2]  = '{1'b1, 64'h0000_0000_8000_000C, 1'b0, 1'b0, 16'h0003, 64'h0000_0000_2222_2222, 2};
    vecs[3]  = '{1'b1, 64'h0000_0000_8000_0008, 1'b1, 1'b0, 16'h0002, 64'h2222_2222_1111_1111, 3};
    vecs[4]  = '{1'b0, 64'h0000_0000_8000_0002, 1'b0, 1'b1, 16'h0000, 64'h0,                   1};
    vecs[5]  = '{1'b1, 64'h0000_0000_8000_0004, 1'b1, 1'b1, 16'h0000, 64'h0,                   1};
    vecs[6]  = '{1'b0, 64'h0000_0000_7FFF_FFFC, 1'b0, 1'b1, 16'h0000, 64'h0,                   1};
    vecs[7]  = '{1'b0, 64'h0000_0000_8004_0000, 1'b0, 1'b1, 16'h0000, 64'h0,                   1};
    vecs[8]  = '{1'b0, 64'h0000_0000_8003_FFFC, 1'b0, 1'b0, 16'hFFFF, 64'h0000_0000_A5A5_FFFF, 2};
    vecs[9]  = '{1'b1, 64'h0000_0000_8003_FFF8, 1'b1, 1'b0, 16'hFFFE, 64'hA5A5_FFFF_A5A4_FFFE, 3};
    vecs[10] = '{1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 16'h0000, 64'h0,                   1};

    // Reset: requests held valid must not be accepted while reset is asserted.
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0000;
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0008; lsu_req_dword = 1'b0;
    ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ifu_req_ready", ifu_req_ready, 0);
    check("rst lsu_req_ready", lsu_req_ready, 0);
    check("rst rom_en", rom_en, 0);
    check("rst ifu_rsp_valid", ifu_rsp_valid, 0);
    check("rst lsu_rsp_valid", lsu_rsp_valid, 0);
    check("rst ifu_rsp_inst", ifu_rsp_inst, 0);
    check("rst lsu_rsp_data", lsu_rsp_data, 0);
    check("rst errs", {ifu_rsp_err, lsu_rsp_err}, 0);
    check("rst state", dbg_state, 0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 11; k++) run_vec(k);

    // Pop of a held response in the same cycle a faulting request reloads the slot.
    tick();
    ifu_rsp_ready = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
    @(negedge clk);
    check("pl fire", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 1'b0;
    tick();
    @(negedge clk);
    check_ifu_held("pl first", 32'h5A5B_0001);
    tick();
    ifu_rsp_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0001;
    @(negedge clk);
    check("pl fault ready", ifu_req_ready, 1);
    check("pl fault rom_en", rom_en, 0);
    check_ifu_held("pl pop", 32'h5A5B_0001);
    tick();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("pl reload valid", ifu_rsp_valid, 1);
    check("pl reload err", ifu_rsp_err, 1);
    check("pl reload inst", ifu_rsp_inst, 0);
    tick();
    @(negedge clk);
    check("pl drained", ifu_rsp_valid, 0);

    // Backpressure on IFU for 5 cycles while the LSU is still served.
    tick();
    ifu_rsp_ready = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0020;
    @(negedge clk);
    check("bp fire", ifu_req_ready, 1);
    tick();
    ifu_req_addr = 64'h8000_0024;
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 3) begin
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0030; lsu_req_dword = 1'b0;
      end
      if (c == 4) lsu_req_valid = 1'b0;
      @(negedge clk);
      check_ifu_held($sformatf("bp hold c%0d", c), 32'h5A52_0008);
      check($sformatf("bp ifu blocked c%0d", c), ifu_req_ready, 0);
      if (c == 3) check("bp lsu granted", lsu_req_ready, 1);
      if (c == 5) begin
        check("bp lsu rsp_valid", lsu_rsp_valid, 1);
        check("bp lsu rsp_data", lsu_rsp_data, 64'h0000_0000_5A56_000C);
      end
    end
    tick();
    ifu_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp accept on pop", ifu_req_ready, 1);
    check_ifu_held("bp pop", 32'h5A52_0008);
    tick();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("bp gap", ifu_rsp_valid, 0);
    tick();
    @(negedge clk);
    check_ifu_held("bp next", 32'h5A53_0009);

    // Both ports request every cycle with consumers ready.
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0000;
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0008; lsu_req_dword = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      @(negedge clk);
`ifdef ROM_ARB_STARVE_GUARD_EN
      exp_lsu = (c % 10 == 8);
`else
      exp_lsu = 1'b0;
`endif
      exp_ifu = (c % 2 == 0) && !exp_lsu;
      check($sformatf("starve ifu c%0d", c), ifu_req_ready, exp_ifu);
      check($sformatf("starve lsu c%0d", c), lsu_req_ready, exp_lsu);
    end
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    repeat (4) tick();

    // Reset asserted while the second dword beat is in flight.
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0008; lsu_req_dword = 1'b1;
    @(negedge clk);
    check("mr fire", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 1'b0;
    tick();
    @(negedge clk);
    check("mr in LSU_RD1", dbg_state, 3);
    #1 rst_n = 1'b0;
    #1;
    check("mr rst state", dbg_state, 0);
    check("mr rst rsp_valid", lsu_rsp_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("mr no stale c%0d", c), lsu_rsp_valid, 0);
      check($sformatf("mr idle c%0d", c), dbg_state, 0);
      tick();
    end
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
